// File: rtl/famicom_pad_emu.sv
// famicom_pad_emu
// Emulates a Famicom/NES 4021-style serial pad. Parallel button state from the
// framework is loaded while the core holds latch high, then shifted out one bit
// per pulse rise on famicom_data (active-low line levels). Also tracks a latch
// counter, the last captured button snapshot and a latch-activity watchdog.
module famicom_pad_emu #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        FILL_BIT    = 1'b1,
  parameter logic [31:0] TIMEOUT     = 32'd1_000_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  buttons,
  input  logic        famicom_latch,
  input  logic        famicom_pulse,
  output logic        famicom_data,
  output logic [7:0]  snapshot,
  output logic [15:0] latch_count,
  output logic        pad_active
);

  localparam int unsigned LAST = SYNC_STAGES - 1;

  logic [SYNC_STAGES-1:0] latch_sync;
  logic [SYNC_STAGES-1:0] pulse_sync;
  logic                   latch_d;
  logic                   pulse_d;
  logic                   latch_s;
  logic                   pulse_s;
  logic                   latch_rise;
  logic                   latch_fall;
  logic                   pulse_rise;

  logic [7:0]             sr;
  logic [3:0]             bit_cnt;
  logic [7:0]             snap_q;
  logic [15:0]            count_q;
  logic [31:0]            wd_cnt;
  logic                   active_q;

  // Synchronize the core's latch and pulse into the clk domain
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      latch_sync <= '0;
      pulse_sync <= '0;
    end else begin
      latch_sync <= {latch_sync[SYNC_STAGES-2:0], famicom_latch};
      pulse_sync <= {pulse_sync[SYNC_STAGES-2:0], famicom_pulse};
    end
  end

  assign latch_s = latch_sync[LAST];
  assign pulse_s = pulse_sync[LAST];

  // Delay flops for edge detection on the synchronized levels
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      latch_d <= 1'b0;
      pulse_d <= 1'b0;
    end else begin
      latch_d <= latch_s;
      pulse_d <= pulse_s;
    end
  end

  assign latch_rise = latch_s & ~latch_d;
  assign latch_fall = ~latch_s & latch_d;
  assign pulse_rise = pulse_s & ~pulse_d;

  // Shift register: transparent load while latched, capture on latch fall,
  // shift on pulse rise; the latch-fall branch precedes the shift so a
  // coincident pulse rise is dropped like on a real 4021
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sr      <= 8'hFF;
      bit_cnt <= '0;
      snap_q  <= '0;
      count_q <= '0;
    end else if (latch_s) begin
      sr      <= ~buttons;
      bit_cnt <= '0;
    end else if (latch_fall) begin
      snap_q  <= ~sr;
      count_q <= count_q + 16'd1;
    end else if (pulse_rise) begin
      sr <= {FILL_BIT, sr[7:1]};
      if (bit_cnt != 4'd8) begin
        bit_cnt <= bit_cnt + 4'd1;
      end
    end
  end

  // Watchdog: re-armed by every latch rise, drops pad_active after TIMEOUT idle cycles
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wd_cnt   <= '0;
      active_q <= 1'b0;
    end else if (latch_rise) begin
      wd_cnt   <= '0;
      active_q <= 1'b1;
    end else begin
      if (wd_cnt != '1) begin
        wd_cnt <= wd_cnt + 32'd1;
      end
      if (wd_cnt >= TIMEOUT - 32'd1) begin
        active_q <= 1'b0;
      end
    end
  end

  assign famicom_data = sr[0];
  assign snapshot     = snap_q;
  assign latch_count  = count_q;
  assign pad_active   = active_q;

endmodule
